// File: rtl/pwm_gen_if.sv
// pwm_gen_if: duty-cycle request channel into pwm_gen.
//
// Handshake: a transfer happens on every clk rising edge where duty_valid and
// duty_ready are both 1. Once duty_valid is raised, the source holds duty_in
// and duty_valid unchanged until that edge. duty_ready depends only on sink
// state, never on duty_valid, so there is no combinational loop.
interface pwm_gen_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] duty_in;
  logic             duty_valid;
  logic             duty_ready;

  modport master (
    output duty_in,
    output duty_valid,
    input  duty_ready
  );

  modport slave (
    input  duty_in,
    input  duty_valid,
    output duty_ready
  );
endinterface

// File: rtl/pwm_gen.sv
// pwm_gen: PWM generator that advances one count per rising edge of the
// divided clock level on tick_in. Duty requests are double-buffered: an
// accepted request waits in a pending register and becomes the active duty
// only at a period boundary (or immediately while disabled). This means every
// period is generated with a single, consistent duty value.
module pwm_gen #(
  parameter int WIDTH  = 8,
  parameter int PERIOD = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  pwm_gen_if.slave         duty,
  output logic             pwm_out,
  output logic             period_done,
  output logic [WIDTH-1:0] active_duty
);

  // Last count of a period, and the duty meaning "high for the whole period".
  localparam logic [WIDTH-1:0] LAST_CNT  = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] FULL_DUTY = WIDTH'(PERIOD);

  logic             tick_q;
  logic [WIDTH-1:0] cnt;
  logic             pending;
  logic [WIDTH-1:0] pending_duty;

  logic             step;
  logic             wrap;
  logic             accept;
  logic             transfer;
  logic [WIDTH-1:0] duty_sat;

  // A step is the clk where tick_in is seen high after being low. Because
  // tick_q clears on reset, a tick_in that is already high right after reset
  // counts as one step.
  assign step     = tick_in & ~tick_q;
  // The wrap condition includes en, so disabling on the wrap step suppresses
  // the strobe.
  assign wrap     = en & step & (cnt == LAST_CNT);
  // The channel is ready whenever the single pending slot is empty.
  assign duty.duty_ready = ~pending;
  assign accept   = duty.duty_valid & ~pending;
  // Promote the pending duty at a period end, or right away while disabled.
  assign transfer = pending & (wrap | ~en);
  // Requests above one full period saturate before they are stored.
  assign duty_sat = (duty.duty_in > FULL_DUTY) ? FULL_DUTY : duty.duty_in;

  // Edge detector and period counter. Disabling parks the counter at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= 1'b0;
      cnt    <= '0;
    end else begin
      tick_q <= tick_in;
      if (!en) begin
        cnt <= '0;
      end else if (step) begin
        if (cnt == LAST_CNT) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end

  // Registered waveform and one-clk end-of-period strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
    end else begin
      pwm_out     <= en & (cnt < active_duty);
      period_done <= wrap;
    end
  end

  // Double buffer: capture into the pending slot, then promote to active.
  // Transfer and accept are exclusive because accept requires an empty slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      pending_duty <= '0;
      active_duty  <= '0;
    end else if (transfer) begin
      active_duty <= pending_duty;
      pending     <= 1'b0;
    end else if (accept) begin
      pending_duty <= duty_sat;
      pending      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen with PERIOD=10, WIDTH=8.
// A behavioural reference model advances on each clk from the same inputs as
// the DUT. Scenario tasks compare the DUT against the model every cycle and
// against hand-derived waveform properties such as high-time per period.
module tb_pwm_gen;
  localparam int W = 8;
  localparam int P = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic         tick_in;
  logic         pwm_out;
  logic         period_done;
  logic [W-1:0] active_duty;

  pwm_gen_if #(.WIDTH(W)) bus ();

  pwm_gen #(.WIDTH(W), .PERIOD(P)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .tick_in     (tick_in),
    .duty        (bus),
    .pwm_out     (pwm_out),
    .period_done (period_done),
    .active_duty (active_duty)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- drivers ----------------
  // Source-side duty requests waiting to be offered on the channel.
  logic [W-1:0] src_q[$];
  bit tick_auto = 1'b0;
  bit tick_lvl  = 1'b0;
  int tick_half = 4;
  int tdiv      = 0;
  bit rdy_prev  = 1'b0;

  // Channel source and divided-clock source. Both change just after the
  // active edge, so the DUT and the model sample stable values.
  always @(posedge clk) begin
    #1;
    if (bus.duty_valid === 1'b1 && rdy_prev && rst !== 1'b1) void'(src_q.pop_front());
    if (src_q.size() != 0) begin
      bus.duty_valid = 1'b1;
      bus.duty_in    = src_q[0];
    end else begin
      bus.duty_valid = 1'b0;
      bus.duty_in    = '0;
    end
    rdy_prev = (bus.duty_ready === 1'b1);
    if (tick_auto) begin
      tdiv++;
      if (tdiv >= tick_half) begin
        tdiv    = 0;
        tick_in = ~tick_in;
      end
    end else begin
      tdiv    = 0;
      tick_in = tick_lvl;
    end
  end

  // ---------------- reference model ----------------
  // exp_q holds the duty the model expects to be pending (at most one entry).
  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  logic [W-1:0] m_active = '0;
  bit           m_tick_prev = 1'b0;
  bit           m_pwm = 1'b0;
  bit           m_done = 1'b0;
  bit           m_step;
  bit           m_end;
  int           m_req;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_tick_prev = 1'b0;
      m_cnt       = 0;
      m_active    = '0;
      m_pwm       = 1'b0;
      m_done      = 1'b0;
      exp_q.delete();
    end else begin
      m_step = (tick_in === 1'b1) && !m_tick_prev;
      m_end  = (en === 1'b1) && m_step && (m_cnt == P - 1);
      // Output reflects the count and duty in effect before this edge.
      m_pwm  = (en === 1'b1) && (m_cnt < int'(m_active));
      m_done = m_end;
      if (exp_q.size() != 0) begin
        if (m_end || en !== 1'b1) m_active = exp_q.pop_front();
      end else if (bus.duty_valid === 1'b1) begin
        m_req = int'(bus.duty_in);
        if (m_req > P) m_req = P;
        exp_q.push_back(W'(m_req));
      end
      if (en !== 1'b1) m_cnt = 0;
      else if (m_step) m_cnt = (m_cnt + 1) % P;
      m_tick_prev = (tick_in === 1'b1);
    end
  end

  function automatic logic [W+2:0] dut_v();
    return {pwm_out, period_done, bus.duty_ready, active_duty};
  endfunction

  function automatic logic [W+2:0] mdl_v();
    return {m_pwm, m_done, (exp_q.size() == 0), m_active};
  endfunction

  // ---------------- synchronisation helpers (no checking) ----------------
  // Waits until the channel has gone busy and come back ready, i.e. the
  // pending duty was promoted. Returns at the promoting clk.
  task automatic wait_transfer(output bit ok);
    bit saw_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.duty_ready !== 1'b1) saw_low = 1'b1;
      else if (saw_low) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cnt(input int c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_cnt == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // One manual count step: tick high for two clks, then low. Reports how many
  // period_done pulses were seen meanwhile.
  task automatic manual_step(output int dn);
    dn = 0;
    tick_lvl = 1'b1;
    repeat (2) begin
      @(negedge clk);
      dn += (period_done === 1'b1);
    end
    tick_lvl = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; tick_auto = 1'b0; tick_lvl = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm_out); end
    checks++; if (period_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", period_done); end
    checks++; if (bus.duty_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.duty_ready); end
    checks++; if (active_duty !== 8'd0) begin errors++; $display("FAIL reset_active got=%0d exp=0", active_duty); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL reset_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
    end
  endtask

  task automatic test_basic_duty();
    bit ok;
    int highs, dones;
    en = 1'b1; tick_half = 4; tick_auto = 1'b1;
    src_q.push_back(8'd3);
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_transfer got=timeout exp=transfer"); end
    checks++;
    if (period_done !== 1'b1 || active_duty !== 8'd3) begin
      errors++; $display("FAIL basic_first_wrap got=done%b/duty%0d exp=done1/duty3", period_done, active_duty);
    end
    for (int w = 0; w < 2; w++) begin
      highs = 0; dones = 0;
      for (int i = 0; i < 8 * P; i++) begin
        @(negedge clk); checks++;
        if (dut_v() !== mdl_v()) begin errors++; $display("FAIL basic_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
        highs += (pwm_out === 1'b1);
        dones += (period_done === 1'b1);
      end
      checks++; if (highs != 24) begin errors++; $display("FAIL basic_high_clks got=%0d exp=24", highs); end
      checks++; if (dones != 1) begin errors++; $display("FAIL basic_done_pulses got=%0d exp=1", dones); end
    end
  endtask

  task automatic test_duty_extremes();
    int req[3]  = '{0, 10, 15};
    int effv[3] = '{0, 10, 10};
    int hiv[3]  = '{0, 80, 80};
    bit ok;
    int highs;
    for (int t = 0; t < 3; t++) begin
      src_q.push_back(W'(req[t]));
      wait_transfer(ok);
      checks++; if (!ok) begin errors++; $display("FAIL extreme_transfer req=%0d got=timeout exp=transfer", req[t]); end
      checks++;
      if (active_duty !== W'(effv[t])) begin
        errors++; $display("FAIL extreme_active req=%0d got=%0d exp=%0d", req[t], active_duty, effv[t]);
      end
      highs = 0;
      for (int i = 0; i < 8 * P; i++) begin
        @(negedge clk); checks++;
        if (dut_v() !== mdl_v()) begin errors++; $display("FAIL extreme_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
        highs += (pwm_out === 1'b1);
      end
      checks++; if (highs != hiv[t]) begin errors++; $display("FAIL extreme_high_clks req=%0d got=%0d exp=%0d", req[t], highs, hiv[t]); end
    end
  endtask

  task automatic test_mid_period_update();
    bit ok;
    src_q.push_back(8'd3);
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_setup got=timeout exp=transfer"); end
    wait_cnt(4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_cnt got=timeout exp=cnt4"); end
    src_q.push_back(8'd7);
    src_q.push_back(8'd9);
    repeat (2) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL mid_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
    end
    checks++;
    if (bus.duty_ready !== 1'b0 || active_duty !== 8'd3) begin
      errors++; $display("FAIL mid_pending got=rdy%b/duty%0d exp=rdy0/duty3", bus.duty_ready, active_duty);
    end
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (period_done === 1'b1) begin ok = 1'b1; break; end
      checks++; if (active_duty !== 8'd3) begin errors++; $display("FAIL mid_hold got=%0d exp=3", active_duty); end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_wrap got=timeout exp=period_done"); end
    checks++;
    if (active_duty !== 8'd7 || bus.duty_ready !== 1'b1) begin
      errors++; $display("FAIL mid_promote got=duty%0d/rdy%b exp=duty7/rdy1", active_duty, bus.duty_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.duty_ready !== 1'b0 || active_duty !== 8'd7) begin
      errors++; $display("FAIL mid_second_accept got=rdy%b/duty%0d exp=rdy0/duty7", bus.duty_ready, active_duty);
    end
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL mid_model2 t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
      if (period_done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || active_duty !== 8'd9) begin
      errors++; $display("FAIL mid_second_promote got=ok%b/duty%0d exp=ok1/duty9", ok, active_duty);
    end
  endtask

  task automatic test_enable_low();
    bit ok;
    int n, highs, dn;
    tick_auto = 1'b0; tick_lvl = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    src_q.push_back(8'd5);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); n++;
      checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL en_low_pwm got=%b exp=0", pwm_out); end
      if (active_duty === 8'd5) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || n != 3) begin errors++; $display("FAIL en_low_latency got=ok%b/clks%0d exp=ok1/clks3", ok, n); end
    checks++; if (bus.duty_ready !== 1'b1) begin errors++; $display("FAIL en_low_ready got=%b exp=1", bus.duty_ready); end
    en = 1'b1;
    highs = 0;
    for (int k = 0; k < P; k++) begin
      repeat (2) begin
        @(negedge clk); checks++;
        if (dut_v() !== mdl_v()) begin errors++; $display("FAIL en_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
      end
      checks++; if (pwm_out !== (k < 5)) begin errors++; $display("FAIL en_first_period step=%0d got=%b exp=%b", k, pwm_out, (k < 5)); end
      highs += (pwm_out === 1'b1);
      manual_step(dn);
    end
    checks++; if (highs != 5) begin errors++; $display("FAIL en_high_steps got=%0d exp=5", highs); end
  endtask

  task automatic test_reset_mid_period();
    bit ok;
    tick_half = 4; tick_auto = 1'b1; en = 1'b1;
    wait_cnt(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_cnt got=timeout exp=cnt6"); end
    src_q.push_back(8'd8);
    repeat (2) @(negedge clk);
    checks++; if (bus.duty_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending got=%b exp=0", bus.duty_ready); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 1'b0 || active_duty !== 8'd0 || bus.duty_ready !== 1'b1 || period_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_state got=pwm%b/duty%0d/rdy%b/done%b exp=pwm0/duty0/rdy1/done0",
                         pwm_out, active_duty, bus.duty_ready, period_done);
    end
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL rstmid_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
      if (period_done === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || active_duty !== 8'd0) begin errors++; $display("FAIL rstmid_lost got=ok%b/duty%0d exp=ok1/duty0", ok, active_duty); end
  endtask

  task automatic test_tick_hold();
    bit ok, stable;
    int dn, dones;
    src_q.push_back(8'd1);
    wait_transfer(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_setup got=timeout exp=transfer"); end
    tick_auto = 1'b0; tick_lvl = 1'b0;
    repeat (4) @(negedge clk);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (pwm_out === 1'b1) begin ok = 1'b1; break; end
      manual_step(dn);
      repeat (2) @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL hold_find_zero got=timeout exp=pwm1"); end
    tick_lvl = 1'b1;
    repeat (20) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL hold_high_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
    end
    tick_lvl = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (pwm_out !== 1'b0) begin errors++; $display("FAIL hold_high_one_step got=%b exp=0", pwm_out); end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (pwm_out !== 1'b0 || period_done !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL hold_low_frozen got=changed exp=stable"); end
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      manual_step(dn); dones += dn;
      repeat (2) begin @(negedge clk); dones += (period_done === 1'b1); end
    end
    checks++; if (pwm_out !== 1'b0 || dones != 0) begin errors++; $display("FAIL hold_cnt9 got=pwm%b/done%0d exp=pwm0/done0", pwm_out, dones); end
    dones = 0;
    manual_step(dn); dones += dn;
    repeat (2) begin @(negedge clk); dones += (period_done === 1'b1); end
    checks++; if (pwm_out !== 1'b1 || dones != 1) begin errors++; $display("FAIL hold_wrap got=pwm%b/done%0d exp=pwm1/done1", pwm_out, dones); end
  endtask

  task automatic test_random();
    tick_auto = 1'b1; en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL random_model t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 2) tick_half = $urandom_range(1, 5);
      if (src_q.size() == 0 && $urandom_range(0, 99) < 5) src_q.push_back(W'($urandom_range(0, 20)));
      rst = ($urandom_range(0, 399) == 0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk); checks++;
      if (dut_v() !== mdl_v()) begin errors++; $display("FAIL random_tail t=%0t got=%h exp=%h", $time, dut_v(), mdl_v()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_basic_duty();
    test_duty_extremes();
    test_mid_period_update();
    test_enable_low();
    test_reset_mid_period();
    test_tick_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
PWM generator that consumes the slow divided clock produced by the team's clock divider. It treats each rising edge of that divided clock as one PWM count step. It produces a PWM waveform whose duty cycle is loaded over a valid/ready handshake. Duty updates are double-buffered and take effect only at period boundaries, so no glitched periods occur.

Parameters:
WIDTH, 8, width of counter, duty input and active duty register
PERIOD, 100, count steps per PWM period; counter runs 0..PERIOD-1; legal range 2..2^WIDTH-1

Ports:
clk  input  1  system clock (50 MHz domain)
rst  input  1  synchronous, active-high reset
en  input  1  PWM enable; 0 forces output low and counter to 0
tick_in  input  1  divided clock level from clock divider (same clk domain, registered source)
duty_in  input  WIDTH  requested duty in count steps (0..PERIOD)
duty_valid  input  1  duty_in valid
duty_ready  output  1  block can accept a new duty (= no pending duty)
pwm_out  output  1  registered PWM output
period_done  output  1  one-clk pulse at end of each PWM period
active_duty  output  WIDTH  duty currently in effect

Behaviour:
- Reset (synchronous, rst=1 at posedge): tick_q=0, cnt=0, active_duty=0, pending=0, pending_duty=0, pwm_out=0, period_done=0. duty_ready reads 1 while pending=0. An in-flight pending duty is discarded.
- Edge detect: tick_q <= tick_in every clk; step = tick_in & ~tick_q.
  - A tick_in already high on the first cycle after reset produces one step.
- Counter (en=1): on step, if cnt==PERIOD-1 then cnt<=0, else cnt<=cnt+1. Held between steps.
- Counter (en=0): cnt<=0 every clk; steps ignored.
- wrap = en & step & (cnt==PERIOD-1).
- period_done <= wrap: a single-clk pulse, registered, asserted the clk after the wrapping step.
- pwm_out <= en & (cnt < active_duty): one-clk latency from cnt/active_duty.
  - active_duty=0 gives constant low.
  - active_duty>=PERIOD gives constant high, with no gap at wrap.
- Handshake:
  - duty_ready = ~pending (combinational from register).
  - Accept when duty_valid & duty_ready: pending_duty <= min(duty_in, PERIOD) (saturating), pending <= 1.
  - duty_valid while duty_ready=0: input not captured. The source holds duty_in/duty_valid until ready.
- Transfer: when pending=1 and (wrap | ~en):
  - active_duty <= pending_duty, pending <= 0.
  - Transfer and accept never occur in the same clk, because ready was 0. Ready rises the clk after transfer.
- With en=0, an accepted duty transfers on the next clk. The first period after en rises uses it.
- Simultaneous wrap and en falling: the en=0 rules win. cnt<=0, pwm_out<=0, no period_done, transfer still occurs.
- Arithmetic: compare unsigned WIDTH bits. The saturating clamp is done before storage. Counter wrap is explicit, never by overflow.

Test Plan:
1. PERIOD=10, en=1, load duty 3, tick_in toggled every 4 clk -> after first wrap, pwm_out high for 3 steps, low for 7 steps, repeating. period_done pulses once per 10 steps, 1 clk wide.
2. Load duty 0, then duty 10, then duty 15 -> constant low; constant high with no low clk across wrap; 15 clamps so active_duty reads 10.
3. Mid-period (cnt=4, active_duty=3) load duty 7 -> duty_ready drops next clk. active_duty stays 3 until wrap, then becomes 7, duty_ready returns to 1 the following clk. A second duty_valid held during pending is accepted only after that.
4. en=0 with a pending duty 5 -> pwm_out=0, cnt=0, active_duty=5 one clk after accept. On en=1, the first period shows 5 high steps.
5. rst asserted mid-period with pending=1, cnt=6 -> next clk: cnt=0, pwm_out=0, active_duty=0, duty_ready=1, pending duty lost.
6. tick_in held high for 20 clk -> exactly one step counted. tick_in held low -> cnt frozen, pwm_out stable.
